// File: rtl/weight_loader.sv
// Run-time coefficient loader: drains MEM_SIZE words from an ap_fifo stream into
// a local array and serves them through a ROM-style address0/ce0/q0 read port.
module weight_loader #(
  parameter int MEM_SIZE   = 288,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] input_V_dout,
  input  logic                  input_V_empty_n,
  output logic                  input_V_read,
  input  logic                  load_start,
  output logic                  load_done,
  input  logic [ADDR_WIDTH-1:0] weight_V_address0,
  input  logic                  weight_V_ce0,
  output logic [DATA_WIDTH-1:0] weight_V_q0
);

  typedef enum logic {LOAD, READY} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   MEM_DEPTH = (ADDR_WIDTH + 1)'(MEM_SIZE);

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_cnt;
  logic                    xfer;
  logic                    last_xfer;
  logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

  assign xfer      = input_V_read;
  assign last_xfer = xfer && (wr_cnt == LAST_ADDR);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= LOAD;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (last_xfer)  state_nxt = READY;
      READY:   if (load_start) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Reset gates the read strobe so no word is popped while the block is held.
  always_comb begin
    input_V_read = 1'b0;
    if (ap_rst_n && state == LOAD) input_V_read = input_V_empty_n;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_cnt    <= '0;
      load_done <= 1'b0;
    end else begin
      if (last_xfer)  wr_cnt <= '0;
      else if (xfer)  wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
      if (last_xfer)                           load_done <= 1'b1;
      else if (state == READY && load_start)   load_done <= 1'b0;
    end
  end

  // Array is deliberately not reset; contents are only trusted once load_done is set.
  always_ff @(posedge ap_clk) begin
    if (xfer) mem[wr_cnt] <= input_V_dout;
  end

  // Non-blocking write/read of the same entry yields the old word (read-before-write).
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      weight_V_q0 <= '0;
    end else if (weight_V_ce0) begin
      if ({1'b0, weight_V_address0} < MEM_DEPTH) weight_V_q0 <= mem[weight_V_address0];
      else                                       weight_V_q0 <= '0;
    end
  end

endmodule
